bin2bcd_seq: RTL and testbench

- Iterative double-dabble converter: takes a binary word and produces packed BCD digits plus a significant-digit count.
- Sits directly upstream of the decimal palindrome checker and feeds it decimal digits.
- The checker then compares digits instead of running a combinational %10 / /10 chain.
- Valid/ready on both sides. One conversion in flight at a time.

---
 rtl/bin2bcd_seq.sv | 94 +++++++++
 tb/tb_bin2bcd_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary to packed BCD converter with digit count
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [2:0]            out_ndig,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state;
    logic [WIDTH-1:0]    bin_sr;
    logic [4*DIGITS-1:0] bcd_acc;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_next;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          ndig_next;

    // All +3 corrections look at pre-shift digits, then the whole pair shifts once.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    end

    always_comb begin
        ndig_next = 3'd1;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) begin
                ndig_next = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bin_sr   <= '0;
            bcd_acc  <= '0;
            cnt      <= '0;
            out_bcd  <= '0;
            out_ndig <= 3'd1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        bin_sr  <= in_bin;
                        bcd_acc <= '0;
                        cnt     <= CNT_W'(WIDTH);
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_sr  <= bin_sr << 1;
                    bcd_acc <= bcd_next;
                    cnt     <= cnt - CNT_W'(1);
                    // The final shift's result is latched straight into the output registers.
                    if (cnt == CNT_W'(1)) begin
                        out_bcd  <= bcd_next;
                        out_ndig <= ndig_next;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq against an arithmetic decimal model
module tb_bin2bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_bin;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] out_bcd;
    logic [2:0]          out_ndig;
    logic                busy;

    int n_assert = 0;
    int n_fail   = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ndig  (out_ndig),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ref_ndig(int unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input int unsigned v, input int hold);
        int k;
        logic [19:0] exp_bcd;
        exp_bcd = ref_bcd(v);
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk("idle_wait", {31'd0, in_ready}, 32'd1);
        in_bin   = WIDTH'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        k = 0;
        while (!out_valid && k < 40) begin
            in_bin    = WIDTH'($urandom);
            out_ready = 1'($urandom);
            tick();
            k++;
        end
        out_ready = 1'b0;
        chk($sformatf("latency_%0d", v), k, WIDTH);
        chk($sformatf("bcd_%0d", v), {12'd0, out_bcd}, {12'd0, exp_bcd});
        chk($sformatf("ndig_%0d", v), {29'd0, out_ndig}, ref_ndig(v));
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_bcd", {12'd0, out_bcd}, {12'd0, exp_bcd});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_hs_bcd_kept", {12'd0, out_bcd}, {12'd0, exp_bcd});
    endtask

    initial begin
        int unsigned vals [3];
        int unsigned rv;
        int idx, ndone, last_cyc, k;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bcd", {12'd0, out_bcd}, 32'd0);
        chk("rst_ndig", {29'd0, out_ndig}, 32'd1);
        reset = 1'b0;
        tick();

        run_conv(0, 0);
        run_conv(12321, 0);
        run_conv(65535, 0);
        run_conv(9999, 0);
        run_conv(1221, 10);

        // abort mid-conversion
        in_bin   = 16'd4444;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd", {12'd0, out_bcd}, 32'd0);
        chk("abort_ndig", {29'd0, out_ndig}, 32'd1);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) k++;
        end
        chk("abort_no_valid", k, 0);
        run_conv(7, 0);

        for (int r = 0; r < 20; r++) begin
            rv = $urandom_range(65535, 0);
            run_conv(rv, $urandom_range(3, 0));
        end

        // back-to-back with both handshakes held high
        vals[0] = 10; vals[1] = 100; vals[2] = 1000;
        idx = 0; ndone = 0; last_cyc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 100 && ndone < 3; c++) begin
            if (in_ready && idx < 3) begin
                in_bin = WIDTH'(vals[idx]);
                idx++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                in_bin = WIDTH'($urandom);
            end
            tick();
            if (out_valid) begin
                chk($sformatf("b2b_bcd_%0d", ndone), {12'd0, out_bcd}, {12'd0, ref_bcd(vals[ndone])});
                chk($sformatf("b2b_ndig_%0d", ndone), {29'd0, out_ndig}, ref_ndig(vals[ndone]));
                if (ndone > 0) chk($sformatf("b2b_spacing_%0d", ndone), c - last_cyc, WIDTH + 2);
                last_cyc = c;
                ndone++;
            end
        end
        chk("b2b_count", ndone, 3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
